// File: rtl/car_warn_pkg.sv
// Shared types and defaults for the car warning chime.
// chime_state_t : states of the chime sequencer
// DEF_*         : default timing constants
// cnt_w()       : bit width needed to hold a counter's maximum value
package car_warn_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DELAY    = 3'd1,
    BEEP_ON  = 3'd2,
    BEEP_OFF = 3'd3,
    DONE     = 3'd4
  } chime_state_t;

  localparam int DEF_CLK_DIV   = 1000;
  localparam int DEF_DLY_TICKS = 3;
  localparam int DEF_ON_TICKS  = 2;
  localparam int DEF_OFF_TICKS = 2;
  localparam int DEF_MAX_BEEPS = 5;

  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every CLK_DIV cycles.
// Clk   : system clock
// RstN  : asynchronous active-low reset
// Clear : restarts the count at 0 (held high keeps the count at 0)
// Tick  : high while the count equals CLK_DIV-1
module tick_prescaler
  import car_warn_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic Clk,
  input  logic RstN,
  input  logic Clear,
  output logic Tick
);

  localparam int CW = cnt_w(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      cnt <= '0;
    end else if (Clear || (cnt == CNT_MAX)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign Tick = (cnt == CNT_MAX);

endmodule

// File: rtl/car_chime_ctrl.sv
// Buzzer sequencer for the car warning alarm: synchronises Alarm, waits a
// grace delay, issues MAX_BEEPS on/off beeps, then stays silent until the
// alarm clears. A driver Mute pulse ends the pattern early.
// Clk     : system clock
// RstN    : asynchronous active-low reset
// Alarm   : asynchronous warning level
// Mute    : synchronous driver-acknowledge pulse
// Buzzer  : buzzer drive
// Active  : pattern in progress (DELAY, BEEP_ON, BEEP_OFF)
// Expired : pattern finished or muted (DONE)
module car_chime_ctrl
  import car_warn_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int DLY_TICKS = DEF_DLY_TICKS,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS,
  parameter int MAX_BEEPS = DEF_MAX_BEEPS
) (
  input  logic Clk,
  input  logic RstN,
  input  logic Alarm,
  input  logic Mute,
  output logic Buzzer,
  output logic Active,
  output logic Expired
);

  localparam int TMAX = (DLY_TICKS > ON_TICKS) ?
                        ((DLY_TICKS > OFF_TICKS) ? DLY_TICKS : OFF_TICKS) :
                        ((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS);
  localparam int TW = cnt_w(TMAX);
  localparam int BW = cnt_w(MAX_BEEPS);

  logic          alarm_p0;
  logic          alarm_p1;
  logic          alarm_s;
  logic          mute_q;
  chime_state_t  state;
  chime_state_t  state_nxt;
  logic          is_run;
  logic          tick;
  logic          ctr_clear;
  logic          timer_done;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_lim_m1;
  logic [BW-1:0] beep_cnt;
  logic          buzzer_d;
  logic          active_d;
  logic          expired_d;

  // Stage: two-flop synchroniser for the asynchronous Alarm level
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      alarm_p0 <= 1'b0;
      alarm_p1 <= 1'b0;
    end else begin
      alarm_p0 <= Alarm;
      alarm_p1 <= alarm_p0;
    end
  end

  assign alarm_s = alarm_p1;
  assign is_run  = (state == DELAY) || (state == BEEP_ON) || (state == BEEP_OFF);

  // Mute is captured only while a pattern runs, so a press in IDLE or DONE
  // cannot carry over into a later pattern.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      mute_q <= 1'b0;
    end else begin
      mute_q <= Mute && is_run;
    end
  end

  // Stage: FSM state register, timers and counters
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .Clk   (Clk),
    .RstN  (RstN),
    .Clear (ctr_clear),
    .Tick  (tick)
  );

  // Timers restart on every state change and stay parked when idle or done.
  assign ctr_clear = (state_nxt != state) || (state == IDLE) || (state == DONE);

  always_comb begin
    tick_lim_m1 = '0;
    case (state)
      DELAY:    tick_lim_m1 = TW'(DLY_TICKS - 1);
      BEEP_ON:  tick_lim_m1 = TW'(ON_TICKS - 1);
      BEEP_OFF: tick_lim_m1 = TW'(OFF_TICKS - 1);
      default:  tick_lim_m1 = '0;
    endcase
  end

  assign timer_done = tick && (tick_cnt == tick_lim_m1);

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      tick_cnt <= '0;
    end else if (ctr_clear) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      beep_cnt <= '0;
    end else if (state == IDLE) begin
      beep_cnt <= '0;
    end else if ((state == BEEP_ON) && (state_nxt == BEEP_OFF)) begin
      beep_cnt <= beep_cnt + 1'b1;
    end
  end

  // Priority: alarm cleared, then mute, then timer expiry, then arming.
  always_comb begin
    state_nxt = state;
    if (!alarm_s) begin
      state_nxt = IDLE;
    end else if (mute_q && is_run) begin
      state_nxt = DONE;
    end else if (is_run && timer_done) begin
      case (state)
        DELAY:    state_nxt = BEEP_ON;
        BEEP_ON:  state_nxt = BEEP_OFF;
        BEEP_OFF: state_nxt = (beep_cnt == BW'(MAX_BEEPS)) ? DONE : BEEP_ON;
        default:  state_nxt = state;
      endcase
    end else if (state == IDLE) begin
      state_nxt = DELAY;
    end
  end

  // Outputs decode the next state so they move on the same edge as the FSM.
  always_comb begin
    buzzer_d  = 1'b0;
    active_d  = 1'b0;
    expired_d = 1'b0;
    case (state_nxt)
      DELAY:    active_d  = 1'b1;
      BEEP_ON:  begin buzzer_d = 1'b1; active_d = 1'b1; end
      BEEP_OFF: active_d  = 1'b1;
      DONE:     expired_d = 1'b1;
      default:  ;
    endcase
  end

  // Stage: registered outputs
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      Buzzer  <= 1'b0;
      Active  <= 1'b0;
      Expired <= 1'b0;
    end else begin
      Buzzer  <= buzzer_d;
      Active  <= active_d;
      Expired <= expired_d;
    end
  end

endmodule

// File: doc/car_chime_ctrl.md
# car_chime_ctrl

Downstream consumer of the car-warning alarm logic. Takes the level `Alarm` signal, which is combinational and driven from asynchronous door, ignition and seat-belt switches, and synchronises it. It then turns it into a timed buzzer pattern: an initial grace delay, a bounded number of on/off beeps, then silence until the alarm clears. It also provides a driver mute input and status outputs for the dashboard.

## Interface
- `CLK_DIV`, 1000: clock cycles per time tick; must be ≥2.
- `DLY_TICKS`, 3: ticks of grace delay before the first beep; must be ≥1.
- `ON_TICKS`, 2: ticks the buzzer is on per beep; must be ≥1.
- `OFF_TICKS`, 2: ticks the buzzer is off between beeps; must be ≥1.
- `MAX_BEEPS`, 5: beeps issued before the block gives up; must be ≥1.

- `Clk`  in  1  system clock; all state changes on the rising edge.
- `RstN`  in  1  reset, asynchronous assert, active-low.
- `Alarm`  in  1  asynchronous level from the warning logic; 1 means a warning condition is present.
- `Mute`  in  1  synchronous driver-acknowledge pulse from the dashboard; any high cycle counts.
- `Buzzer`  out  1  buzzer drive; 1 means sounding.
- `Active`  out  1  1 in DELAY, BEEP_ON and BEEP_OFF.
- `Expired`  out  1  1 in DONE, meaning the pattern has finished or been muted.

## Operation
- **Synchroniser.** `Alarm` passes through 2 flops to give `AlarmS`. Both flops reset to 0.
- **States.**
  - IDLE (reset state).
  - DELAY.
  - BEEP_ON.
  - BEEP_OFF.
  - DONE.
- **Prescaler and counters.**
  - The prescaler counts 0..CLK_DIV-1. `Tick` is high for one cycle when the count equals CLK_DIV-1.
  - The prescaler and the tick counter clear on every state change and hold at 0 in IDLE and DONE.
  - The beep counter clears in IDLE.
- **Transition priority** (highest first), evaluated each cycle:
  1. `AlarmS`=0 → IDLE, from any state.
  2. `Mute`=1 in DELAY, BEEP_ON or BEEP_OFF → DONE.
  3. Timer expiry, where the tick counter reaches its limit on a `Tick`:
     - DELAY → BEEP_ON after DLY_TICKS ticks.
     - BEEP_ON → BEEP_OFF after ON_TICKS ticks; the beep counter increments.
     - BEEP_OFF → DONE after OFF_TICKS ticks if the beep counter equals MAX_BEEPS, otherwise → BEEP_ON.
  4. IDLE with `AlarmS`=1 → DELAY.
- **DONE** is held while `AlarmS`=1. Re-arming requires `AlarmS` to fall and then rise again.
- **Outputs** are registered and decoded from the next state, so they change on the same edge as the state. Reset values: `Buzzer`=0, `Active`=0, `Expired`=0.
- **Widths.** All counters are sized with `$clog2` of their maximum value plus 1. Counters never wrap, because the transitions above occur first.

## Timing
- Let `Alarm` be stable high before edge k:
  - `AlarmS`=1 after edge k+1.
  - State is DELAY and `Active`=1 after edge k+2.
- DELAY lasts exactly DLY_TICKS·CLK_DIV cycles, so `Buzzer` rises after edge k+2+DLY_TICKS·CLK_DIV.
- Each beep is high for exactly ON_TICKS·CLK_DIV cycles and low for exactly OFF_TICKS·CLK_DIV cycles.
- `Expired` rises on the same edge that ends the final BEEP_OFF.
- `Alarm` falling: `Buzzer`, `Active` and `Expired` go to 0 exactly 2 cycles after `AlarmS` falls, counting from the edge that samples the low input. An in-progress beep is truncated, not completed.
- `Mute`: the state is DONE on the next edge after `Mute` is sampled high, and `Buzzer` drops on that same edge. `Mute` in IDLE or DONE is ignored.
- Simultaneous `Mute` and timer expiry: `Mute` wins.
- Simultaneous `AlarmS` fall and `Mute`: the state goes to IDLE.
- Reset mid-pattern: all outputs go to 0 immediately (asynchronously), and the synchroniser clears. After release, the block starts from IDLE. A still-high `Alarm` restarts the full pattern, including the delay.

## Structure
- Package `car_warn_pkg` holds:
  - the state enum `chime_state_t` (IDLE, DELAY, BEEP_ON, BEEP_OFF, DONE);
  - the default timing constants;
  - a width helper function.
- Sub-module `tick_prescaler`:
  - parameter CLK_DIV;
  - inputs `Clk`, `RstN`, `Clear`;
  - output `Tick`.
- The FSM, tick counter, beep counter and synchroniser live in the top module.

## Test plan
All scenarios use CLK_DIV=4, DLY_TICKS=2, ON_TICKS=3, OFF_TICKS=1, MAX_BEEPS=2.
- **Full pattern.** `Alarm` rises before edge 0 and is held high → `Active` rises at edge 2 and `Buzzer` is high over edges 10–21 and 26–37; `Expired`=1 from edge 42 onward; `Buzzer` is never high again.
- **Early clear.** `Alarm` drops during the first beep (sampled at edge 14) → all outputs are 0 from edge 16; re-raising `Alarm` repeats the full 8-cycle delay.
- **Mute.** `Mute` is a 1-cycle pulse sampled at edge 12 → `Buzzer`=0 and `Expired`=1 from edge 13; releasing `Alarm` clears `Expired` 2 cycles after it is sampled low.
- **Mute tie.** `Mute` is asserted on the cycle in which the final BEEP_OFF expires → DONE is entered and `Buzzer` never rises again.
- **Async reset.** `RstN` is pulled low mid-beep with no clock edge → `Buzzer`, `Active` and `Expired` are 0 immediately; after release with `Alarm` still high, `Active` rises 2 edges later.
- **Glitch.** A 1-cycle `Alarm` pulse → `Active` is high for exactly 1 cycle and `Buzzer` stays 0.
